adder_operand_loader: RTL and testbench
=======================================

Name: adder_operand_loader

Overview:
Upstream operand-capture stage for the 4-bit ripple-carry adder datapath on the board. It takes raw slide-switch data and a raw active-low pushbutton. It debounces the button and sequences two presses to latch operand A, then operand B plus carry-in. It presents {op_a, op_b, op_cin} to the adder with a valid/ready handshake and holds them stable until the consumer accepts them.

Parameters:
- WIDTH, 4, operand width in bits; matches the adder width.
- DB_CYCLES, 500000, number of consecutive stable synchronized samples required before the debounced button state changes (10 ms at 50 MHz); must be ≥2.
- CNT_W, $clog2(DB_CYCLES)+1, debounce counter width (derived; not overridden).

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- sw_data, input, WIDTH, operand value from the slide switches; quasi-static, sampled directly.
- sw_cin, input, 1, carry-in switch; sampled together with operand B.
- key_load_n, input, 1, raw pushbutton, active-low (0 = pressed), asynchronous to clk.
- op_a, output, WIDTH, latched operand A.
- op_b, output, WIDTH, latched operand B.
- op_cin, output, 1, latched carry-in.
- out_valid, output, 1, operands complete and stable.
- out_ready, input, 1, consumer accepts operands when high together with out_valid.
- phase, output, 2, FSM state for LEDs: 00 = WAIT_A, 01 = WAIT_B, 10 = READY.

Behaviour:
- Reset (async assert, sync release):
  - op_a = 0, op_b = 0, op_cin = 0, out_valid = 0, phase = 00.
  - Both synchronizer flops = 1; debounced state db = 1 (released); counter = 0.
- Synchronizer: two flops on key_load_n produce s2; nothing else samples key_load_n.
- Debounce, per edge:
  - If s2 == db: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: db <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to db before the count completes restarts the count.
- press_evt (combinational) = (s2 == 0) && (db == 1) && (cnt == DB_CYCLES-1). It is high for exactly one cycle per debounced press. Release transitions produce no event.
- Latency: key_load_n low and stable from before edge e1 gives a capture on edge e(DB_CYCLES+2). With DB_CYCLES = 4 this is the 6th edge.
- FSM transitions:
  - WAIT_A: on press_evt, op_a <= sw_data, go to WAIT_B.
  - WAIT_B: on press_evt, op_b <= sw_data and op_cin <= sw_cin, go to READY. out_valid is registered and goes high on the same edge.
  - READY: out_valid = 1. On an edge with out_ready = 1, out_valid <= 0 and go to WAIT_A. press_evt is ignored in READY, even if it coincides with acceptance.
- Operand registers change only on their capture edges. They hold their values after acceptance until the next capture. The switches have no effect outside capture edges.
- out_ready is ignored while out_valid = 0.
- Reset asserted mid-sequence returns everything to reset values immediately; any partial operand A is discarded.
- A button held pressed produces one event only. A new event requires a debounced release and then a new debounced press.
- The block does no arithmetic; widths pass straight through to the adder.

Test Plan:
All scenarios use DB_CYCLES = 4.
1. Reset, then key_load_n held high for 20 cycles → out_valid = 0, phase = 00, op_a = op_b = 0, op_cin = 0 throughout.
2. sw_data = 4'hA, press held for 10 cycles, release, then sw_data = 4'h7, sw_cin = 1, press again → op_a = A captured on the 6th edge after the first press, phase = 01. After the second press: op_b = 7, op_cin = 1, out_valid = 1, phase = 10.
3. Bounce pattern 0,1,0,0,1,0,0,0,0 on key_load_n → exactly one press_evt, on the 6th edge after the final stable low begins; a single capture occurs.
4. In READY, hold out_ready = 0 for 5 cycles while toggling sw_data and pressing the key → out_valid stays 1 and op_a, op_b, op_cin are unchanged. Then out_ready = 1 for one cycle → out_valid = 0 next edge, phase = 00, operands retained.
5. Assert rst_n = 0 mid-debounce while in WAIT_B with op_a = 5 → op_a = 0, phase = 00, and no spurious capture after reset release even with key_load_n still low.
6. Hold key_load_n low for 50 cycles in WAIT_A → exactly one capture; phase = 01 and no advance to READY.

Source files
------------

// File: rtl/adder_operand_loader.sv
// rtl/adder_operand_loader.sv - debounced two-press operand capture with valid/ready output
module adder_operand_loader #(
    parameter  int WIDTH     = 4,
    parameter  int DB_CYCLES = 500000,
    localparam int CNT_W     = $clog2(DB_CYCLES) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             sw_cin,
    input  logic             key_load_n,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       phase
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        READY  = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic              db_q, db_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic              op_cin_q, op_cin_d;
    logic              out_valid_q, out_valid_d;
    logic              s2;
    logic              press_evt;

    assign s2 = sync_q[1];

    // Only a debounced high-to-low transition is an event; releases are silent.
    assign press_evt = !s2 && db_q && (cnt_q == CNT_MAX);

    always_comb begin
        sync_d = {sync_q[0], key_load_n};
        db_d   = db_q;
        cnt_d  = cnt_q;
        if (s2 == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = s2;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        out_valid_d = out_valid_q;
        case (state_q)
            WAIT_A: begin
                if (press_evt) begin
                    op_a_d  = sw_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (press_evt) begin
                    op_b_d      = sw_data;
                    op_cin_d    = sw_cin;
                    out_valid_d = 1'b1;
                    state_d     = READY;
                end
            end
            READY: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = WAIT_A;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = WAIT_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            db_q        <= 1'b1;
            cnt_q       <= '0;
            state_q     <= WAIT_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            db_q        <= db_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_cin    = op_cin_q;
    assign out_valid = out_valid_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// tb/tb_adder_operand_loader.sv - scoreboard bench for adder_operand_loader
module tb_adder_operand_loader;

    localparam int W  = 4;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] sw_data = '0;
    logic         sw_cin = 1'b0;
    logic         key_load_n = 1'b1;
    logic         out_ready = 1'b0;
    logic [W-1:0] op_a, op_b;
    logic         op_cin, out_valid;
    logic [1:0]   phase;

    adder_operand_loader #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .sw_data(sw_data), .sw_cin(sw_cin),
        .key_load_n(key_load_n), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .out_valid(out_valid), .out_ready(out_ready), .phase(phase)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;
    bit chk_en = 0;

    // Reference: the button counts as pressed once its synchronized level has
    // sat at the opposite of the debounced level for DB consecutive samples.
    logic         hist[$];
    logic         m_db;
    int           m_state;
    logic [W-1:0] m_a, m_b;
    logic         m_cin;
    logic [2*W:0] sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i < DB + 2; i++) hist.push_back(1'b1);
            m_db = 1'b1;
            m_state = 0;
            m_a = '0;
            m_b = '0;
            m_cin = 1'b0;
            sbq.delete();
        end else begin
            logic flip, press, dummy;
            hist.push_back(key_load_n);
            dummy = hist.pop_front();
            flip = 1'b1;
            for (int i = 0; i < DB; i++) if (hist[i] == m_db) flip = 1'b0;
            press = flip && m_db;
            if (flip) m_db = !m_db;
            case (m_state)
                0: if (press) begin m_a = sw_data; m_state = 1; end
                1: if (press) begin
                    m_b = sw_data;
                    m_cin = sw_cin;
                    m_state = 2;
                    sbq.push_back({m_a, m_b, m_cin});
                end
                default: if (out_ready) m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("outputs", {20'd0, phase, out_valid, op_a, op_b, op_cin},
                {20'd0, 2'(m_state), 1'(m_state == 2), m_a, m_b, m_cin});
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("handshake_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [2*W:0] e;
                    e = sbq.pop_front();
                    chk("handshake_data", {23'd0, op_a, op_b, op_cin}, {23'd0, e});
                    hs_cnt++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        logic [8:0] bounce;
        bounce = 9'b010010000;
        #1 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        #1 chk_en = 1;

        cyc(20);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_phase", {30'd0, phase}, 32'd0);

        sw_data = 4'hA; key_load_n = 1'b0; cyc(10);
        key_load_n = 1'b1; cyc(10);
        chk("capture_a", {26'd0, phase, op_a}, {26'd0, 2'b01, 4'hA});
        sw_data = 4'h7; sw_cin = 1'b1; key_load_n = 1'b0; cyc(10);
        key_load_n = 1'b1; cyc(10);
        chk("capture_b", {22'd0, phase, out_valid, op_a, op_b, op_cin},
            {22'd0, 2'b10, 1'b1, 4'hA, 4'h7, 1'b1});

        out_ready = 1'b0;
        key_load_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sw_data = W'($urandom); sw_cin = 1'($urandom); cyc(1);
        end
        cyc(3);
        key_load_n = 1'b1; cyc(10);
        chk("ready_hold", {22'd0, phase, out_valid, op_a, op_b, op_cin},
            {22'd0, 2'b10, 1'b1, 4'hA, 4'h7, 1'b1});
        out_ready = 1'b1; cyc(1);
        out_ready = 1'b0; cyc(1);
        chk("accepted", {22'd0, phase, out_valid, op_a, op_b, op_cin},
            {22'd0, 2'b00, 1'b0, 4'hA, 4'h7, 1'b1});

        sw_data = 4'h5;
        for (int i = 8; i >= 0; i--) begin
            key_load_n = bounce[i]; cyc(1);
        end
        cyc(6);
        key_load_n = 1'b1; cyc(10);
        chk("bounce_capture", {26'd0, phase, op_a}, {26'd0, 2'b01, 4'h5});

        key_load_n = 1'b0; cyc(3);
        rst_n = 1'b0;
        #1 chk("reset_async", {25'd0, phase, out_valid, op_a}, 32'd0);
        cyc(2);
        rst_n = 1'b1; cyc(2);
        key_load_n = 1'b1; cyc(15);
        chk("no_spurious", {25'd0, phase, out_valid, op_a}, 32'd0);

        sw_data = 4'h9; key_load_n = 1'b0; cyc(50);
        key_load_n = 1'b1; cyc(10);
        chk("long_hold", {25'd0, phase, out_valid, op_a}, {25'd0, 2'b01, 1'b0, 4'h9});

        for (int n = 0; n < 400; n++) begin
            int len;
            key_load_n = 1'($urandom);
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                sw_data = W'($urandom);
                sw_cin = 1'($urandom);
                out_ready = ($urandom_range(0, 3) == 0);
                cyc(1);
            end
        end
        out_ready = 1'b0;
        cyc(2);
        chk("handshakes_seen", {31'd0, hs_cnt > 2}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout time=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
